// File: rtl/btn_event_queue.sv
// Debounced N-button front end queueing timestamped events in a FWFT FIFO; btn_level rise -> evt_valid in 2 cycles.
// Full FIFO parks one event per channel in its pending bit; BTN_EVT_RELEASE_EN adds release events.
module btn_event_queue #(
    parameter int N_BTN      = 5,
    parameter int CH_W       = 3,
    parameter int DEB_CYCLES = 100000,
    parameter int DEB_W      = 17,
    parameter int TS_W       = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CH_W-1:0]  evt_chan,
    output logic [TS_W-1:0]  evt_time,
    output logic             evt_rel,
    output logic [N_BTN-1:0] btn_level,
    output logic [AW:0]      fifo_count,
    output logic             overflow
);
`ifdef BTN_EVT_RELEASE_EN
    localparam int NREQ = 2 * N_BTN;
`else
    localparam int NREQ = N_BTN;
`endif
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [CH_W-1:0] chan;
        logic [TS_W-1:0] ts;
`ifdef BTN_EVT_RELEASE_EN
        logic            rel;
`endif
    } evt_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] stable_d;
    logic [DEB_W-1:0] deb_cnt [N_BTN];
    logic [TS_W-1:0]  timestamp;

    logic [N_BTN-1:0] pend_press;
    logic [TS_W-1:0]  ts_press [N_BTN];
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] gnt_press;
    logic [N_BTN-1:0] drop_press;
`ifdef BTN_EVT_RELEASE_EN
    logic [N_BTN-1:0] pend_rel;
    logic [TS_W-1:0]  ts_rel [N_BTN];
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] gnt_rel;
    logic [N_BTN-1:0] drop_rel;
`endif

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  grant;
    logic             drop_any;
    logic             push;
    logic             pop;
    logic             can_push;
    evt_t             wr_evt;
    evt_t             head;

    evt_t             mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Synchroniser and per-channel debounce counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn_in;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + 1'b1;
        end
    end

    assign rise       = stable & ~stable_d;
    assign gnt_press  = grant[N_BTN-1:0];
    assign drop_press = rise & pend_press & ~gnt_press;

    // A granted bit may be re-armed by a new edge in the same cycle; a dropped edge keeps the older timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_press <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                ts_press[i] <= '0;
            end
        end else begin
            pend_press <= (pend_press & ~gnt_press) | rise;
            for (int i = 0; i < N_BTN; i++) begin
                if (rise[i] && !drop_press[i]) begin
                    ts_press[i] <= timestamp;
                end
            end
        end
    end

`ifdef BTN_EVT_RELEASE_EN
    assign fall     = ~stable & stable_d;
    assign gnt_rel  = grant[NREQ-1:N_BTN];
    assign drop_rel = fall & pend_rel & ~gnt_rel;
    assign req      = {pend_rel, pend_press};
    assign drop_any = (|drop_press) | (|drop_rel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_rel <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                ts_rel[i] <= '0;
            end
        end else begin
            pend_rel <= (pend_rel & ~gnt_rel) | fall;
            for (int i = 0; i < N_BTN; i++) begin
                if (fall[i] && !drop_rel[i]) begin
                    ts_rel[i] <= timestamp;
                end
            end
        end
    end
`else
    assign req      = pend_press;
    assign drop_any = |drop_press;
`endif

    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    assign can_push  = (count != FULL_CNT) || pop;

    // Fixed priority: lowest request index wins, so presses outrank releases.
    always_comb begin
        logic found;
        grant  = '0;
        wr_evt = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !found && can_push) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N_BTN; i++) begin
            if (grant[i]) begin
                wr_evt.chan = CH_W'(i);
                wr_evt.ts   = ts_press[i];
            end
`ifdef BTN_EVT_RELEASE_EN
            if (grant[N_BTN+i]) begin
                wr_evt.chan = CH_W'(i);
                wr_evt.ts   = ts_rel[i];
                wr_evt.rel  = 1'b1;
            end
`endif
        end
    end

    assign push = |grant;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_evt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop_any) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Head fields are gated so an empty queue presents zeros rather than stale storage.
    assign head       = mem[rd_ptr];
    assign evt_chan   = evt_valid ? head.chan : '0;
    assign evt_time   = evt_valid ? head.ts : '0;
`ifdef BTN_EVT_RELEASE_EN
    assign evt_rel    = evt_valid & head.rel;
`else
    assign evt_rel    = 1'b0;
`endif
    assign btn_level  = stable;
    assign fifo_count = count;

endmodule
